// File: rtl/fetch_unit.sv
// Instruction fetch unit: request / wait / hold FSM with branch-aware next-PC selection.
// Optional misaligned-target trap is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        advance,
    input  logic        branch_taken,
    input  logic        branch_reg,
    input  logic [63:0] sext_imm,
    input  logic [63:0] reg_target,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
`ifdef FETCH_ALIGN_CHECK_EN
        , S_FAULT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic [63:0] target;

    // Register target wins over the PC-relative one; arithmetic wraps silently.
    assign target = branch_reg   ? reg_target :
                    branch_taken ? instr_pc_q + (sext_imm << 2) :
                                   instr_pc_q + 64'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            S_REQ: begin
                if (imem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    pc_d    = target;
                    state_d = S_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (target[1:0] != 2'b00) state_d = S_FAULT;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_FAULT: begin
                state_d = S_FAULT;
            end
`endif
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 64'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Outputs are forced quiet for the whole reset cycle, not just after the first edge.
    assign imem_req    = !reset && (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr       = reset ? 32'h0 : instr_q;
    assign instr_pc    = reset ? 64'h0 : instr_pc_q;
    assign instr_valid = !reset && (state_q == S_HOLD);

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = !reset && (state_q == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port imem_req  output  1  SHALL request an instruction read.
REQ-005 Port imem_addr  output  64  SHALL carry the byte address of the read.
REQ-006 Port imem_ready  input  1  SHALL indicate the memory accepts the request this cycle.
REQ-007 Port imem_rvalid  input  1  SHALL mark imem_rdata valid.
REQ-008 Port imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-009 Port instr  output  32  SHALL present the held instruction to decode.
REQ-010 Port instr_pc  output  64  SHALL present the address of instr.
REQ-011 Port instr_valid  output  1  SHALL mark instr/instr_pc valid.
REQ-012 Port advance  input  1  SHALL signal that the consumer has retired instr.
REQ-013 Port branch_taken  input  1  SHALL select the PC-relative target.
REQ-014 Port branch_reg  input  1  SHALL select the register target (BR).
REQ-015 Port sext_imm  input  64  SHALL carry the sign-extended branch offset in words.
REQ-016 Port reg_target  input  64  SHALL carry the register branch target.
REQ-017 Port fetch_fault  output  1  SHALL flag a misaligned target (FETCH_ALIGN_CHECK_EN only).

Function
REQ-018 The FSM SHALL have exactly these states: S_REQ, S_WAIT, S_HOLD, plus S_FAULT when FETCH_ALIGN_CHECK_EN is defined.
REQ-019 In S_REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_ready=1 SHALL move the FSM to S_WAIT, otherwise it SHALL stay in S_REQ.
REQ-020 In S_WAIT, imem_req SHALL be 0; imem_rvalid=1 SHALL capture imem_rdata into instr, pc into instr_pc, and move the FSM to S_HOLD.
REQ-021 imem_rvalid SHALL be ignored outside S_WAIT, including any stale response arriving after reset.
REQ-022 In S_HOLD, instr_valid SHALL be 1 and instr/instr_pc SHALL remain stable until advance=1.
REQ-023 On advance=1 in S_HOLD, the next pc SHALL be: reg_target if branch_reg=1; else instr_pc + (sext_imm << 2) if branch_taken=1; else instr_pc + 4. The FSM SHALL then move to S_REQ.
REQ-024 branch_reg SHALL take priority over branch_taken when both are 1.
REQ-025 All pc arithmetic SHALL be 64-bit modulo 2^64; wrap-around SHALL NOT be flagged.
REQ-026 advance, branch_taken and branch_reg SHALL be ignored outside S_HOLD.
REQ-027 instr_valid SHALL be 0 in every state except S_HOLD.
REQ-028 Minimum latency: request accepted in cycle N, rvalid in N+1, and instr_valid=1 in N+2.

Reset
REQ-029 While reset=1: pc = RESET_PC, state = S_REQ, imem_req = 0, instr = 0, instr_pc = 0, instr_valid = 0, fetch_fault = 0.
REQ-030 The first imem_req SHALL assert in the first cycle after reset deasserts.
REQ-031 Reset in any state, including mid-S_WAIT, SHALL abandon the outstanding fetch.

Configuration
REQ-032 With FETCH_ALIGN_CHECK_EN defined, a selected next pc with bits [1:0] not equal to 0 SHALL move the FSM to S_FAULT instead of S_REQ.
REQ-033 In S_FAULT, fetch_fault SHALL be 1 and imem_req SHALL be 0, and the state SHALL be held until reset.
REQ-034 Without FETCH_ALIGN_CHECK_EN, S_FAULT SHALL not exist, fetch_fault SHALL be tied to 0, and misaligned targets SHALL be fetched as given.

Verification
REQ-035 Reset release with RESET_PC=0, imem_ready=1, rvalid one cycle later with data 32'h91000421 -> imem_addr=0; instr_valid=1 two cycles after acceptance; instr=32'h91000421; instr_pc=0.
REQ-036 Sequential flow: advance with no branch at instr_pc=0x100 -> next imem_addr=0x104.
REQ-037 Branch at instr_pc=0x100 with branch_taken=1 and sext_imm=64'hFFFF_FFFF_FFFF_FFFE -> next imem_addr=0xF8.
REQ-038 branch_reg=1 and branch_taken=1 together, with reg_target=0x2000 -> next imem_addr=0x2000.
REQ-039 Backpressure: imem_ready=0 for 3 cycles, and reset asserted mid-S_WAIT -> imem_req and imem_addr are held; after reset, a later rvalid is ignored and a fresh fetch starts at RESET_PC.
REQ-040 With FETCH_ALIGN_CHECK_EN: branch_reg=1 and reg_target=0x2002 -> fetch_fault=1, no further imem_req until reset.
